// File: rtl/psm_sync_generator.sv
// psm_sync_generator
// Period carrier and sync-pulse generator for the phase-shift-modulation path.
// A free-running period counter drives two one-cycle pulses per switching
// period: oSych1 at count 0 and oSych2 at the programmable phase count.
// Period/phase updates are double-buffered: a validated load sits in the
// pending registers until the next period boundary (or immediately in IDLE),
// so downstream logic never observes a half-updated period.
//
// Optional feature macro: PSM_SYNC_EXT_EN
//   When defined, adds input iSYNC_EXT (asynchronous). Its rising edge,
//   after a 2-FF synchronizer and edge detector, forces a period boundary
//   while running, so this generator can be slaved to a master bridge.
//   When undefined, the port is absent and the counter free-runs.
module psm_sync_generator #(
    parameter int BITS_DATA     = 16,
    parameter int FREQ_DEFAULT  = 4000,
    parameter int PHASE_DEFAULT = 2000,
    parameter int FREQ_MIN      = 3
) (
    input  logic                 CLK,
    input  logic                 RST,
`ifdef PSM_SYNC_EXT_EN
    input  logic                 iSYNC_EXT,
`endif
    input  logic                 iEN,
    input  logic [BITS_DATA-1:0] iFREQUENCY,
    input  logic [BITS_DATA-1:0] iPHASE,
    input  logic                 iLOAD,
    output logic                 oLOAD_ACK,
    output logic                 oCFG_ERR,
    output logic [BITS_DATA-1:0] oCNT,
    output logic                 oSych1,
    output logic                 oSych2,
    output logic                 oRUN
);

    // Two-state controller: IDLE holds the counter at zero, RUN counts.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [BITS_DATA-1:0] C_FREQ_DEFAULT  = BITS_DATA'(FREQ_DEFAULT);
    localparam logic [BITS_DATA-1:0] C_PHASE_DEFAULT = BITS_DATA'(PHASE_DEFAULT);
    localparam logic [BITS_DATA-1:0] C_FREQ_MIN      = BITS_DATA'(FREQ_MIN);
    localparam logic [BITS_DATA-1:0] C_ZERO          = '0;
    localparam logic [BITS_DATA-1:0] C_ONE           = BITS_DATA'(1);

    // State and datapath registers
    logic [0:0]           r_state;
    logic [BITS_DATA-1:0] r_cnt;
    logic [BITS_DATA-1:0] r_freq_act;
    logic [BITS_DATA-1:0] r_phase_act;
    logic [BITS_DATA-1:0] r_freq_pend;
    logic [BITS_DATA-1:0] r_phase_pend;
    logic                 r_pend;

    // Registered outputs
    logic                 r_sych1;
    logic                 r_sych2;
    logic                 r_load_ack;
    logic                 r_cfg_err;

    // Next-state and decode signals
    logic [0:0]           w_state_next;
    logic [BITS_DATA-1:0] w_cnt_next;
    logic [BITS_DATA-1:0] w_freq_next;
    logic [BITS_DATA-1:0] w_phase_next;
    logic [BITS_DATA-1:0] w_freq_pend_next;
    logic [BITS_DATA-1:0] w_phase_pend_next;
    logic                 w_pend_next;
    logic                 w_accept;
    logic                 w_reject;
    logic                 w_wrap;
    logic                 w_boundary_run;
    logic                 w_apply;
    logic                 w_ext_edge;

`ifdef PSM_SYNC_EXT_EN
    logic r_ext_meta;
    logic r_ext_sync;
    logic r_ext_prev;

    // Bring the asynchronous external sync into CLK and keep the previous
    // synchronized level for rising-edge detection.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ext_meta <= 1'b0;
            r_ext_sync <= 1'b0;
            r_ext_prev <= 1'b0;
        end else begin
            r_ext_meta <= iSYNC_EXT;
            r_ext_sync <= r_ext_meta;
            r_ext_prev <= r_ext_sync;
        end
    end

    assign w_ext_edge = r_ext_sync & ~r_ext_prev;
`else
    assign w_ext_edge = 1'b0;
`endif

    // Load validation, boundary detection and next-value computation.
    always_comb begin
        w_accept = iLOAD && (iFREQUENCY >= C_FREQ_MIN) && (iPHASE <= iFREQUENCY);
        w_reject = iLOAD && !w_accept;

        w_wrap = (r_cnt == r_freq_act);

        // A running boundary is either the natural wrap or a forced external
        // edge; both collapse into a single boundary when they coincide.
        // Dropping iEN is not a boundary: the pending load waits for IDLE.
        w_boundary_run = (r_state == ST_RUN) && iEN && (w_wrap || w_ext_edge);

        // IDLE applies a pending load on the very next edge.
        w_apply = r_pend && ((r_state == ST_IDLE) || w_boundary_run);

        w_state_next = iEN ? ST_RUN : ST_IDLE;

        w_cnt_next = r_cnt + C_ONE;
        if ((w_state_next == ST_IDLE) || (r_state == ST_IDLE) || w_boundary_run) begin
            w_cnt_next = C_ZERO;
        end

        w_freq_next  = r_freq_act;
        w_phase_next = r_phase_act;
        if (w_apply) begin
            w_freq_next  = r_freq_pend;
            w_phase_next = r_phase_pend;
        end

        // A load arriving together with an apply becomes the next pending
        // value; the older pending value is the one that goes active now.
        w_freq_pend_next  = r_freq_pend;
        w_phase_pend_next = r_phase_pend;
        w_pend_next       = r_pend && !w_apply;
        if (w_accept) begin
            w_freq_pend_next  = iFREQUENCY;
            w_phase_pend_next = iPHASE;
            w_pend_next       = 1'b1;
        end
    end

    // Controller state, counter and double-buffered configuration.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= ST_IDLE;
            r_cnt        <= C_ZERO;
            r_freq_act   <= C_FREQ_DEFAULT;
            r_phase_act  <= C_PHASE_DEFAULT;
            r_freq_pend  <= C_FREQ_DEFAULT;
            r_phase_pend <= C_PHASE_DEFAULT;
            r_pend       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_freq_act   <= w_freq_next;
            r_phase_act  <= w_phase_next;
            r_freq_pend  <= w_freq_pend_next;
            r_phase_pend <= w_phase_pend_next;
            r_pend       <= w_pend_next;
        end
    end

    // Sync pulses and status strobes, decoded from next values so they line
    // up with the registered count they describe.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sych1    <= 1'b0;
            r_sych2    <= 1'b0;
            r_load_ack <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_sych1    <= (w_state_next == ST_RUN) && (w_cnt_next == C_ZERO);
            r_sych2    <= (w_state_next == ST_RUN) && (w_cnt_next == w_phase_next);
            r_load_ack <= w_apply;
            r_cfg_err  <= w_reject;
        end
    end

    assign oCNT      = r_cnt;
    assign oRUN      = (r_state == ST_RUN);
    assign oSych1    = r_sych1;
    assign oSych2    = r_sych2;
    assign oLOAD_ACK = r_load_ack;
    assign oCFG_ERR  = r_cfg_err;

endmodule

// File: tb/tb_psm_sync_generator.sv
// Testbench for psm_sync_generator (default build, external sync absent).
// Directed scenarios followed by randomized loads/enables, every cycle checked
// against a period-bookkeeping reference model.
module tb_psm_sync_generator;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iEN;
    logic        iLOAD;
    logic [15:0] iFREQUENCY;
    logic [15:0] iPHASE;
    logic        oLOAD_ACK;
    logic        oCFG_ERR;
    logic [15:0] oCNT;
    logic        oSych1;
    logic        oSych2;
    logic        oRUN;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    psm_sync_generator #(
        .BITS_DATA    (16),
        .FREQ_DEFAULT (4000),
        .PHASE_DEFAULT(2000),
        .FREQ_MIN     (3)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .iEN       (iEN),
        .iFREQUENCY(iFREQUENCY),
        .iPHASE    (iPHASE),
        .iLOAD     (iLOAD),
        .oLOAD_ACK (oLOAD_ACK),
        .oCFG_ERR  (oCFG_ERR),
        .oCNT      (oCNT),
        .oSych1    (oSych1),
        .oSych2    (oSych2),
        .oRUN      (oRUN)
    );

    // Reference model: position inside the current period, the active
    // period/phase, and at most one waiting configuration (a queue).
    typedef struct { int f; int p; } cfg_t;
    bit   m_run;
    int   m_pos;
    int   m_freq;
    int   m_phase;
    cfg_t m_wait[$];
    bit   m_ack;
    bit   m_err;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(bit rst, bit en, bit ld, int f, int p);
        bit   start_period;
        cfg_t c;
        if (rst) begin
            m_run = 0; m_pos = 0; m_freq = 4000; m_phase = 2000;
            m_wait.delete(); m_ack = 0; m_err = 0;
            return;
        end
        start_period = 0;
        if (!m_run) begin
            // Idle: anything waiting is adopted straight away.
            start_period = (m_wait.size() != 0);
            m_pos = 0;
            m_run = en;
        end else if (!en) begin
            m_run = 0;
            m_pos = 0;
        end else if (m_pos == m_freq) begin
            m_pos = 0;
            start_period = (m_wait.size() != 0);
        end else begin
            m_pos = m_pos + 1;
        end
        m_ack = 0;
        if (start_period) begin
            c = m_wait.pop_front();
            m_freq = c.f; m_phase = c.p; m_ack = 1;
        end
        m_err = 0;
        if (ld) begin
            if (f >= 3 && p <= f) begin
                c.f = f; c.p = p;
                m_wait.delete();
                m_wait.push_back(c);
                $display("t=%0t load freq=%0d phase=%0d accepted", $time, f, p);
            end else begin
                m_err = 1;
                $display("t=%0t load freq=%0d phase=%0d rejected", $time, f, p);
            end
        end
    endtask

    task automatic check_all();
        chk("cnt",  32'(oCNT),      32'(m_pos));
        chk("run",  32'(oRUN),      32'(m_run));
        chk("sych1", 32'(oSych1),   32'(m_run && m_pos == 0));
        chk("sych2", 32'(oSych2),   32'(m_run && m_pos == m_phase));
        chk("ack",  32'(oLOAD_ACK), 32'(m_ack));
        chk("err",  32'(oCFG_ERR),  32'(m_err));
    endtask

    // One clock: drive at the falling edge, update the model at the rising
    // edge, compare at the following falling edge.
    task automatic step(bit rst, bit en, bit ld, int f, int p);
        RST = rst; iEN = en; iLOAD = ld;
        iFREQUENCY = f[15:0]; iPHASE = p[15:0];
        @(posedge CLK);
        model_edge(rst, en, ld, f, p);
        @(negedge CLK);
        check_all();
    endtask

    task automatic run_n(int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0);
    endtask

    task automatic run_to(int target, int budget);
        int n;
        n = 0;
        while (m_pos != target && n < budget) begin
            step(0, 1, 0, 0, 0);
            n++;
        end
        chk("reach_count", 32'(oCNT), 32'(target));
    endtask

    initial begin
        RST = 1'b1; iEN = 1'b0; iLOAD = 1'b0; iFREQUENCY = '0; iPHASE = '0;

        // Reset state
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Default period 4001 cycles, sych2 at 2000
        step(0, 1, 0, 0, 0);
        chk("enable_sych1", 32'(oSych1), 32'd1);
        run_n(2 * 4001 + 5);

        // Load 99/25 at count 1000; takes effect at the next wrap
        run_to(1000, 5000);
        step(0, 1, 1, 99, 25);
        run_n(3200);

        // Rejected loads: period too small, phase beyond period
        run_to(10, 200);
        step(0, 1, 1, 2, 1);
        step(0, 1, 1, 40, 50);
        run_n(250);

        // Two loads in one period: only the second becomes active
        run_to(5, 200);
        step(0, 1, 1, 99, 25);
        run_to(20, 200);
        step(0, 1, 1, 49, 0);
        run_n(200);

        // Load presented in the wrap cycle itself
        run_to(49, 200);
        step(0, 1, 1, 70, 70);
        run_n(200);

        // Drop enable at count 37 with a load pending, then re-enable
        run_to(30, 200);
        step(0, 1, 1, 60, 59);
        run_to(37, 200);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 1, 10, 3);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("reenable_sych1", 32'(oSych1), 32'd1);
        run_n(150);

        // Randomized loads and enable drops
        for (int i = 0; i < 3000; i++) begin
            step(0, $urandom_range(99) != 0, $urandom_range(19) == 0,
                 int'($urandom_range(60)), int'($urandom_range(70)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/psm_sync_generator.md
# psm_sync_generator

Period carrier and synchronisation generator for the phase-shift-modulation path. It runs a free period counter and emits two one-cycle sync pulses per switching period: primary at count 0, secondary at a programmable phase offset. These pulses feed the PSM controller's `iSych1`/`iSych2` inputs. Period and phase updates are double-buffered and applied only at a period boundary, so the controller never sees a torn period.

## Interface
Parameters:
- `BITS_DATA`, 16: width of counter, period and phase words.
- `FREQ_DEFAULT`, 4000: active period value after reset.
- `PHASE_DEFAULT`, 2000: active phase value after reset.
- `FREQ_MIN`, 3: smallest accepted period value.

Ports:
- Clocking and reset: reset `RST`, synchronous, active-high; clock `CLK`.
- `CLK`, input, 1: system clock.
- `RST`, input, 1: synchronous active-high reset.
- `iEN`, input, 1: run enable. Level-sensitive.
- `iFREQUENCY`, input, BITS_DATA: requested terminal count. Period is iFREQUENCY+1 cycles.
- `iPHASE`, input, BITS_DATA: requested count at which `oSych2` fires.
- `iLOAD`, input, 1: one-cycle strobe that captures `iFREQUENCY`/`iPHASE`.
- `oLOAD_ACK`, output, 1: one-cycle pulse when captured values become active.
- `oCFG_ERR`, output, 1: one-cycle pulse when a load is rejected.
- `oCNT`, output, BITS_DATA: current period count.
- `oSych1`, output, 1: primary sync pulse.
- `oSych2`, output, 1: phase-shifted sync pulse.
- `oRUN`, output, 1: high while in state RUN.

## Operation
- Registers:
  - `freq_act`, `phase_act`: active values.
  - `freq_pend`, `phase_pend`, `pend`: pending load.
  - `cnt`: period counter.
- States: IDLE and RUN.
  - IDLE → RUN when `iEN`=1.
  - RUN → IDLE when `iEN`=0.
  - RST forces IDLE.
- IDLE behaviour: `cnt` held at 0; `oSych1`, `oSych2` and `oRUN` are 0.
- RUN behaviour:
  - `cnt` increments each cycle.
  - When `cnt==freq_act` it wraps to 0. That is a period boundary.
- `oSych1`=1 exactly in cycles where state is RUN and `cnt==0`.
- `oSych2`=1 exactly in cycles where state is RUN and `cnt==phase_act`.
  - `phase_act==0` makes it coincide with `oSych1`.
  - `phase_act==freq_act` makes it fire in the last cycle of the period.
- Load validation: `iLOAD` is accepted only if `iFREQUENCY>=FREQ_MIN` and `iPHASE<=iFREQUENCY`.
  - Accepted load: values are written to the pend registers and `pend` is set.
  - Rejected load: `oCFG_ERR` pulses; pend registers and `pend` are unchanged.
- Applying a pending load:
  - In RUN, it is applied on the wrap edge. `freq_act`/`phase_act` take the pend values, `pend` clears and `oLOAD_ACK` pulses.
  - In IDLE, it is applied on the next edge with the same `oLOAD_ACK` pulse.
- Second accepted `iLOAD` while `pend`=1: overwrites the pend values. Only one ack is issued, for the values that become active.
- `iLOAD` in the same cycle as a wrap: the old pending values (if any) apply at this wrap. The new values are captured as pending for the next wrap.
- Falling `iEN` mid-period:
  - Next cycle: state is IDLE and `cnt`=0.
  - Any pending load is applied next cycle per the IDLE rule.
- Arithmetic: unsigned, BITS_DATA wide, no saturation needed because `cnt<=freq_act` always.

## Timing
- Reset values:
  - `oCNT`=0, `oSych1`=0, `oSych2`=0, `oRUN`=0, `oLOAD_ACK`=0, `oCFG_ERR`=0.
  - `freq_act`=FREQ_DEFAULT, `phase_act`=PHASE_DEFAULT, `pend`=0.
- Enable latency: with `iEN` high at edge N, after edge N `oRUN`=1, `oCNT`=0 and `oSych1`=1. After edge N+1, `oCNT`=1.
- Period: `oSych1` pulses are exactly freq_act+1 cycles apart.
- `oSych2` follows `oSych1` by phase_act cycles.
- `oCFG_ERR` appears in the cycle after the `iLOAD` edge.
- `oLOAD_ACK` is high in the first cycle of the new period, i.e. the same cycle as that period's `oSych1`.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- Macro `PSM_SYNC_EXT_EN`: compiles in input `iSYNC_EXT` (1 bit, asynchronous) for slaving to a master bridge.
- With the macro:
  - `iSYNC_EXT` passes through a 2-FF synchronizer and a rising-edge detector.
  - A detected edge in RUN forces a period boundary. `cnt` becomes 0, `oSych1` pulses and any pending load applies with `oLOAD_ACK`.
  - The first `oSych1` occurs 3 cycles after `iSYNC_EXT` rises, i.e. after the third `CLK` edge.
  - Edges are ignored in IDLE.
  - A forced boundary coinciding with a natural wrap produces a single boundary.
- Without the macro: the port does not exist and the counter is free-running only.

## Test plan
- Reset, then `iEN`=1: `oSych1` at `oCNT`=0 every 4001 cycles and `oSych2` at `oCNT`=2000. `oLOAD_ACK` and `oCFG_ERR` stay 0.
- Load `iFREQUENCY`=99, `iPHASE`=25 at count 1000: `oLOAD_ACK` only at the next wrap. The next period is 100 cycles with `oSych2` at 25.
- `iLOAD` with `iFREQUENCY`=2, or with `iPHASE`=50 and `iFREQUENCY`=40: one `oCFG_ERR` pulse and the period is unchanged.
- Two loads in one period (99/25 then 49/0): one ack, period 50, and `oSych2` coincident with `oSych1`.
- Drop `iEN` at count 37 with a load pending: `oCNT`=0, `oRUN`=0 and `oLOAD_ACK` pulse next cycle. Re-enable: `oSych1` in the first RUN cycle.
- With `PSM_SYNC_EXT_EN` defined, pulse `iSYNC_EXT` at count 500 with period 4000: `oCNT`=0 and `oSych1` 3 cycles later, after which the period resumes at 4001 cycles.
